// File: rtl/chunk_stats_pkg.sv
// Shared state encoding, accumulator widths and divider constants for chunk_stats.
// Also provides the 32-bit saturation helper used on the variance result.
package chunk_stats_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DIV_MEAN,
    ST_DIV_VAR,
    ST_FINAL
  } state_t;

  localparam int SUM_W  = 48;
  localparam int SQ_W   = 80;
  localparam int ITER_W = 7;

  localparam logic [ITER_W-1:0] MEAN_ITERS = 7'd48;
  localparam logic [ITER_W-1:0] VAR_ITERS  = 7'd80;

  localparam logic [31:0] SAT_VAL = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat32(input logic [SQ_W-1:0] x);
    return (x[SQ_W-1:32] != '0) ? SAT_VAL : x[31:0];
  endfunction

endpackage

// File: rtl/chunk_stats_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle after a load cycle.
// done is high in the cycle whose closing edge writes the final quotient bit.
module seq_divider
  import chunk_stats_pkg::*;
#(
  parameter int W  = 80,
  parameter int DW = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [W-1:0]      numer,
  input  logic [DW-1:0]     denom,
  input  logic [ITER_W-1:0] iters,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      quotient
);

  logic [DW-1:0]     rem;
  logic [DW-1:0]     denom_r;
  logic [ITER_W-1:0] count;
  logic [DW:0]       shifted;
  logic [DW:0]       diff;
  logic              fits;

  // The numerator is consumed MSB-first out of the quotient register itself;
  // callers with a shorter numerator left-align it and run fewer iterations.
  always_comb begin
    shifted = {rem, quotient[W-1]};
    diff    = shifted - {1'b0, denom_r};
    fits    = (shifted >= {1'b0, denom_r});
  end

  assign done = busy && (count == ITER_W'(1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rem      <= '0;
      denom_r  <= '0;
      count    <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start && !busy) begin
      rem      <= '0;
      denom_r  <= denom;
      count    <= iters;
      busy     <= 1'b1;
      quotient <= numer;
    end else if (busy) begin
      rem      <= fits ? diff[DW-1:0] : shifted[DW-1:0];
      quotient <= {quotient[W-2:0], fits};
      count    <= count - ITER_W'(1);
      if (count == ITER_W'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chunk_stats.sv
// chunk_stats: reads samples si..ei-1 through a one-cycle-latency memory port and reports mean and variance.
// Build option CHUNK_STATS_SAMPLE_VAR_EN selects the n-1 (sample) variance; default is population variance.
module chunk_stats
  import chunk_stats_pkg::*;
#(
  parameter int MAX_LEN_W = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] si,
  input  logic [31:0] ei,
  input  logic        start,
  output logic [31:0] index,
  input  logic [31:0] value,
  output logic        done,
  output logic        err,
  output logic [31:0] mean,
  output logic [31:0] variance
);

  localparam logic [31:0] MAX_N = 32'((64'd1 << MAX_LEN_W) - 64'd1);

  state_t state;
  state_t next_state;

  logic [31:0]          ei_r;
  logic [31:0]          last_idx;
  logic [31:0]          req_diff;
  logic                 req_bad;
  logic [MAX_LEN_W-1:0] n_r;
  logic                 bad_r;
  logic                 acc_en;
  logic [SUM_W-1:0]     sum;
  logic [SQ_W-1:0]      sumsq;
  logic [63:0]          value_sq;
  logic [31:0]          mean_r;
  logic [31:0]          mean_src;
  logic [63:0]          mean_sq;
  logic [31:0]          var_final;
  logic [SQ_W-1:0]      var_numer;
  logic [MAX_LEN_W-1:0] var_denom;

  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [SQ_W-1:0]      div_numer;
  logic [SQ_W-1:0]      div_quotient;
  logic [MAX_LEN_W-1:0] div_denom;
  logic [ITER_W-1:0]    div_iters;

  assign req_diff = ei - si;
  assign req_bad  = (ei <= si) || (req_diff > MAX_N);
  assign last_idx = ei_r - 32'd1;
  assign value_sq = 64'(value) * 64'(value);

  // During the variance load the divider still holds the fresh mean; in FINAL
  // the divider holds the variance quotient, so the captured copy is used instead.
  assign mean_src = (state == ST_FINAL) ? mean_r : div_quotient[31:0];
  assign mean_sq  = 64'(mean_src) * 64'(mean_src);

`ifdef CHUNK_STATS_SAMPLE_VAR_EN
  logic [SQ_W-1:0] n_mean_sq;

  always_comb begin
    n_mean_sq = SQ_W'(n_r) * SQ_W'(mean_sq);
    var_numer = (sumsq > n_mean_sq) ? (sumsq - n_mean_sq) : '0;
    var_denom = n_r - MAX_LEN_W'(1);
    var_final = (n_r == MAX_LEN_W'(1)) ? '0 : sat32(div_quotient);
  end
`else
  logic [SQ_W-1:0] pop_excess;

  always_comb begin
    var_numer  = sumsq;
    var_denom  = n_r;
    pop_excess = (div_quotient > SQ_W'(mean_sq)) ? (div_quotient - SQ_W'(mean_sq)) : '0;
    var_final  = sat32(pop_excess);
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A rejected request still spends one cycle in FETCH (with no address issued)
  // so that its done lands two cycles after the accepting edge.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    div_numer  = '0;
    div_denom  = '0;
    div_iters  = MEAN_ITERS;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bad_r) begin
          next_state = ST_FINAL;
        end else if (index == last_idx) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        next_state = ST_DIV_MEAN;
      end
      ST_DIV_MEAN: begin
        div_start = !div_busy;
        div_numer = {sum, {(SQ_W-SUM_W){1'b0}}};
        div_denom = n_r;
        div_iters = MEAN_ITERS;
        if (div_done) begin
          next_state = ST_DIV_VAR;
        end
      end
      ST_DIV_VAR: begin
        div_start = !div_busy;
        div_numer = var_numer;
        div_denom = var_denom;
        div_iters = VAR_ITERS;
        if (div_done) begin
          next_state = ST_FINAL;
        end
      end
      ST_FINAL: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      index    <= '0;
      ei_r     <= '0;
      n_r      <= '0;
      bad_r    <= 1'b0;
      acc_en   <= 1'b0;
      sum      <= '0;
      sumsq    <= '0;
      mean_r   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      mean     <= '0;
      variance <= '0;
    end else begin
      done   <= 1'b0;
      acc_en <= (state == ST_FETCH) && !bad_r;

      if (acc_en) begin
        sum   <= sum + SUM_W'(value);
        sumsq <= sumsq + SQ_W'(value_sq);
      end

      if ((state == ST_IDLE) && start) begin
        ei_r  <= ei;
        n_r   <= req_diff[MAX_LEN_W-1:0];
        bad_r <= req_bad;
        sum   <= '0;
        sumsq <= '0;
        if (!req_bad) begin
          index <= si;
        end
      end

      if ((state == ST_FETCH) && !bad_r && (index != last_idx)) begin
        index <= index + 32'd1;
      end

      if ((state == ST_DIV_VAR) && div_start) begin
        mean_r <= div_quotient[31:0];
      end

      if (state == ST_FINAL) begin
        done     <= 1'b1;
        err      <= bad_r;
        mean     <= bad_r ? '0 : mean_r;
        variance <= bad_r ? '0 : var_final;
      end
    end
  end

  seq_divider #(
    .W  (SQ_W),
    .DW (MAX_LEN_W)
  ) u_div (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (div_start),
    .numer    (div_numer),
    .denom    (div_denom),
    .iters    (div_iters),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

endmodule

// File: tb/tb_chunk_stats.sv
// Directed, table-driven bench for chunk_stats with a one-cycle-latency sample memory.
// Expected variances are carried for both population and sample builds.
module tb_chunk_stats;

`ifdef CHUNK_STATS_SAMPLE_VAR_EN
  localparam bit SAMPLE_MODE = 1'b1;
`else
  localparam bit SAMPLE_MODE = 1'b0;
`endif

  localparam int BUDGET = 400;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] m;
    logic [31:0] vp;
    logic [31:0] vs;
    logic        er;
    int          lat;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] si = '0;
  logic [31:0] ei = '0;
  logic [31:0] value = '0;
  logic [31:0] index;
  logic        done;
  logic        err;
  logic [31:0] mean;
  logic [31:0] variance;

  logic [31:0] mem [0:31];
  logic [31:0] exp_idx = '0;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        vecs [9];

  chunk_stats #(.MAX_LEN_W(16)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .si       (si),
    .ei       (ei),
    .start    (start),
    .index    (index),
    .value    (value),
    .done     (done),
    .err      (err),
    .mean     (mean),
    .variance (variance)
  );

  always #5 Clk = ~Clk;

  // Sample memory: data for the address presented in one cycle appears in the next.
  always @(posedge Clk) value <= mem[index[4:0]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, output int lat);
    @(negedge Clk);
    si    = s;
    ei    = e;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge Clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int          lat;
    logic [31:0] ev;
    ev = SAMPLE_MODE ? v.vs : v.vp;
    applyStimulus(v.s, v.e, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    checkOutput({tag, " mean"}, mean, v.m);
    checkOutput({tag, " variance"}, variance, ev);
    checkOutput({tag, " err"}, 32'(err), 32'(v.er));
    if (!v.er) exp_idx = v.e - 32'd1;
    checkOutput({tag, " index"}, index, exp_idx);
    @(posedge Clk);
    #1;
    checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
    checkOutput({tag, " mean hold"}, mean, v.m);
  endtask

  initial begin
    int lat;
    int stray;
    int first;
    int second;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 32'd2;  mem[1] = 32'd4;  mem[2] = 32'd4;  mem[3] = 32'd4;
    mem[4] = 32'd5;  mem[5] = 32'd5;  mem[6] = 32'd7;  mem[7] = 32'd9;
    mem[8] = 32'd0;  mem[9] = 32'hFFFF_FFFF;
    mem[12] = 32'd10; mem[13] = 32'd20; mem[14] = 32'd30; mem[15] = 32'd40;

    //           si          ei             mean           pop var        sample var     err   latency
    vecs[0] = '{32'd0,      32'd8,        32'd5,         32'd4,         32'd4,         1'b0, 140};
    vecs[1] = '{32'd8,      32'd10,       32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 134};
    vecs[2] = '{32'd5,      32'd5,        32'd0,         32'd0,         32'd0,         1'b1, 2};
    vecs[3] = '{32'd7,      32'd3,        32'd0,         32'd0,         32'd0,         1'b1, 2};
    vecs[4] = '{32'd0,      32'h0001_0000, 32'd0,        32'd0,         32'd0,         1'b1, 2};
    vecs[5] = '{32'd12,     32'd16,       32'd25,        32'd125,       32'd166,       1'b0, 136};
    vecs[6] = '{32'd0,      32'd1,        32'd2,         32'd0,         32'd0,         1'b0, 133};
    vecs[7] = '{32'd1,      32'd3,        32'd4,         32'd0,         32'd0,         1'b0, 134};
    vecs[8] = '{32'd3,      32'd7,        32'd5,         32'd3,         32'd5,         1'b0, 136};

    repeat (3) @(negedge Clk);
    checkOutput("reset index", index, 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset mean", mean, 32'd0);
    checkOutput("reset variance", variance, 32'd0);
    Rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Single full-scale sample: mean is the sample itself, variance is zero.
    @(negedge Clk);
    mem[3] = 32'hFFFF_FFFF;
    runVector("single max", '{32'd3, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 133});
    mem[3] = 32'd4;

    // Reset in the middle of an index sweep must abandon the chunk silently.
    @(negedge Clk);
    si    = 32'd0;
    ei    = 32'd8;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    checkOutput("midreset index", index, 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset mean", mean, 32'd0);
    checkOutput("midreset variance", variance, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    exp_idx = 32'd0;
    stray = 0;
    repeat (160) begin
      @(posedge Clk);
      #1;
      if (done === 1'b1) stray++;
    end
    checkOutput("midreset stale done", 32'(stray), 32'd0);
    runVector("after reset", vecs[0]);

    // Start held high: the request re-launches in the done cycle, so pulses are 135 apart.
    @(negedge Clk);
    si    = 32'd0;
    ei    = 32'd2;
    start = 1'b1;
    @(posedge Clk);
    #1;
    first  = -1;
    second = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge Clk);
      #1;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = k;
        end else if (second < 0) begin
          second = k;
          checkOutput("held start mean", mean, 32'd3);
          checkOutput("held start variance", variance, SAMPLE_MODE ? 32'd2 : 32'd1);
        end
      end
    end
    start = 1'b0;
    checkOutput("held start first done", 32'(first), 32'd134);
    checkOutput("held start second done", 32'(second), 32'd269);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chunk_stats.md
CHUNK_STATS -- requirements
Module: chunk_stats

Interface
REQ-001 Parameter: MAX_LEN_W, default 16, width of the maximum chunk length (max n = 2^MAX_LEN_W - 1).
REQ-002 Clk  input  1  clock, all state on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 si  input  32  chunk start index (inclusive), sampled with start.
REQ-005 ei  input  32  chunk end index (exclusive), sampled with start.
REQ-006 start  input  1  request; honoured only in IDLE.
REQ-007 index  output  32  sample-memory read address.
REQ-008 value  input  32  unsigned sample; valid exactly one cycle after index is presented.
REQ-009 done  output  1  one-cycle pulse, results valid.
REQ-010 err  output  1  set with done when the request was rejected.
REQ-011 mean  output  32  floor(sum/n).
REQ-012 variance  output  32  variance per REQ-022, saturated.

Function
REQ-013 States: IDLE, FETCH, DRAIN, DIV_MEAN, DIV_VAR, FINAL.
REQ-014 IDLE with start=1: latch si/ei, n=ei-si; go to FETCH.
REQ-015 If ei<=si or n>2^MAX_LEN_W-1: go to FINAL; mean=0, variance=0, err=1.
REQ-016 FETCH: index issues si, si+1, ..., ei-1, one address per cycle, n cycles; value sampled the following cycle is accumulated.
REQ-017 Accumulators: sum 48 bits, sumsq 80 bits (value*value, zero-extended); cleared on entry to FETCH.
REQ-018 DRAIN: one cycle accumulating the last sample; index holds ei-1.
REQ-019 DIV_MEAN: sum/n via sequential divider, 1 load + 48 iteration cycles.
REQ-020 DIV_VAR: numerator/denominator per REQ-022, 1 load + 80 iteration cycles.
REQ-021 FINAL: one cycle; outputs registered; done=1; return to IDLE.
REQ-022 Population mode: variance = floor(sumsq/n) - mean^2, clamped at 0.
REQ-023 Variance result exceeding 32 bits saturates to 32'hFFFFFFFF; mean always fits.
REQ-024 Latency: done asserted exactly n+132 cycles after the edge that samples start (valid requests).
REQ-025 Rejected request: done asserted 2 cycles after the start edge.
REQ-026 start while not IDLE is ignored; no queuing.
REQ-027 start in the FINAL cycle is ignored; start in the cycle after done is accepted.
REQ-028 mean/variance/err hold their values until the next FINAL.
REQ-029 index holds its last value outside FETCH/DRAIN.

Reset
REQ-030 On Rst low, regardless of state: state=IDLE; index=0, done=0, err=0, mean=0, variance=0; accumulators and divider cleared.
REQ-031 A mid-operation reset abandons the chunk; no done is produced for it.

Configuration
REQ-032 CHUNK_STATS_SAMPLE_VAR_EN defined: variance = floor((sumsq - n*mean^2)/(n-1)), numerator clamped at 0; n=1 gives variance 0, err 0.
REQ-033 CHUNK_STATS_SAMPLE_VAR_EN undefined: population formula of REQ-022.
REQ-034 Latency is identical in both modes.

Structure
REQ-035 Shared package: state encoding, accumulator widths (48/80), divider iteration counts, saturation constant.
REQ-036 One sub-module: seq_divider, parameterised restoring unsigned divider, 1 bit per cycle, with start/done/quotient ports; instantiated once and reused for both divisions.
REQ-037 The index/value ports match the chunker's per-engine memory port, so four instances can serve four ports in parallel.

Verification
REQ-038 Memory 2,4,4,4,5,5,7,9 at addresses 0..7; si=0, ei=8 -> mean=5, variance=4 (sample mode: 4), err=0, done at cycle 140.
REQ-039 si=5, ei=5 -> done 2 cycles later, err=1, mean=0, variance=0; no index sweep.
REQ-040 Single sample 0xFFFFFFFF, si=3, ei=4 -> mean=0xFFFFFFFF, variance=0 in both modes.
REQ-041 Samples 0, 0xFFFFFFFF alternating, n=2 -> mean=0x7FFFFFFF; variance saturates to 0xFFFFFFFF.
REQ-042 Rst pulsed low mid-FETCH, then new start with si=0, ei=8 -> no stale done; correct results per REQ-038.
REQ-043 start held high continuously -> one request per IDLE visit; each done followed by re-acceptance on the next cycle.
